// File: rtl/uart_tx_fifo_if.sv
// Bus-side signals of the buffered UART transmitter: the write strobe and byte in,
// and the status bits and serial line out.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 8
);
  logic                     wr_en;
  logic [7:0]               wr_data;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     busy;
  logic                     txd;

  modport master (output wr_en, output wr_data,
                  input full, input count, input busy, input txd);
  modport slave  (input wr_en, input wr_data,
                  output full, output count, output busy, output txd);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a DEPTH-entry byte FIFO feeding a start/data/stop
// serialiser, LSB first.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t         r_state, w_state_nxt;
  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [7:0]     r_shift;
  logic [BW-1:0]  r_baud, w_baud_nxt;
  logic [2:0]     r_bit_idx, w_bit_idx_nxt;
  logic           r_txd, w_txd_nxt;
  logic           w_push, w_pop, w_bit_end, w_full, w_has_data;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_has_data = (r_count != '0);
  assign w_push     = bus.wr_en && !w_full;
  assign w_bit_end  = (r_baud == BAUD_LAST);

  assign bus.full  = w_full;
  assign bus.count = r_count;
  assign bus.busy  = (r_state != S_IDLE) || w_has_data;
  assign bus.txd   = r_txd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_txd_nxt     = r_txd;
    w_baud_nxt    = r_baud + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    case (r_state)
      S_IDLE: begin
        w_txd_nxt  = 1'b1;
        w_baud_nxt = '0;
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        w_txd_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_baud_nxt    = '0;
          w_bit_idx_nxt = 3'd0;
          w_txd_nxt     = r_shift[0];
        end
      end
      S_DATA: begin
        w_txd_nxt = r_shift[r_bit_idx];
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_txd_nxt     = r_shift[r_bit_idx + 3'd1];
          end
        end
      end
      S_STOP: begin
        w_txd_nxt = 1'b1;
        if (w_bit_end) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap
          if (w_has_data) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txd     <= 1'b1;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_txd     <= w_txd_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_shift  <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: per-cycle comparison against a frame-timing
// reference model, a txd line decoder, a vector table and directed corner sequences.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk, reset;
  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: waiting bytes, bytes sent, edge index and frame timing
  logic [7:0] mq[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] cur = 8'h00;
  int e = 0, free_at = 0, pop_edge = -1000, rst_cnt = 0;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic [2:0] cnt;
    logic       full;
    logic       busy;
    logic       txd;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  function automatic logic model_txd();
    int t;
    if (e >= free_at) return 1'b1;
    t = (e - pop_edge) / CPB;
    if (t == 0) return 1'b0;
    if (t == 9) return 1'b1;
    return cur[t-1];
  endfunction

  task automatic step(input logic wr, input logic [7:0] d);
    int pre;
    bus.wr_en   = wr;
    bus.wr_data = d;
    @(posedge clk);
    e++;
    pre = mq.size();
    if (pre > 0 && e >= free_at) begin
      cur = mq.pop_front();
      sent_q.push_back(cur);
      pop_edge = e;
      free_at  = e + 10 * CPB;
    end
    if (wr && pre < DEPTH) mq.push_back(d);
    #1;
    bus.wr_en = 1'b0;
    chk("txd",   bus.txd,   model_txd());
    chk("count", bus.count, mq.size());
    chk("full",  bus.full,  mq.size() == DEPTH);
    chk("busy",  bus.busy,  (e < free_at) || (mq.size() != 0));
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || e < free_at) && n < 3000) begin
      step(1'b0, 8'h00);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
    end
    repeat (3) step(1'b0, 8'h00);
  endtask

  task automatic rx_vs_model();
    chk("rx_len", rx_q.size(), sent_q.size());
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
      chk("rx_byte", rx_q[i], sent_q[i]);
  endtask

  task automatic clear_lists();
    rx_q.delete();
    sent_q.delete();
  endtask

  // line decoder: samples mid-bit on the falling clock edge
  initial begin : decoder
    logic       prev;
    logic [7:0] b;
    logic       ok;
    int         rc;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) prev = 1'b1;
      else if (prev && !bus.txd) begin
        ok = 1'b1;
        rc = rst_cnt;
        repeat (CPB/2) @(negedge clk);
        if (bus.txd !== 1'b0) ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          b[j] = bus.txd;
        end
        repeat (CPB) @(negedge clk);
        if (bus.txd !== 1'b1 || rc != rst_cnt || reset) ok = 1'b0;
        if (ok) rx_q.push_back(b);
        prev = bus.txd;
      end else prev = bus.txd;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] wl[$];
    logic [7:0] d;
    int k;

    vecs[0] = '{1'b1, 8'h10, 3'd1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h12, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h13, 3'd3, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h14, 3'd4, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h15, 3'd4, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 3'd4, 1'b1, 1'b1, 1'b0};

    bus.wr_en = 1'b0; bus.wr_data = 8'h00;
    reset = 1'b1;
    #3;
    chk("rst_txd", bus.txd, 1); chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0); chk("rst_full", bus.full, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step(1'b0, 8'h00);

    // single frame 0x55 with hand-computed waveform
    clear_lists();
    step(1'b1, 8'h55);
    for (k = 1; k <= 41; k++) begin
      step(1'b0, 8'h00);
      if (k <= 4)       chk("f55_start", bus.txd, 0);
      else if (k <= 36) chk("f55_data",  bus.txd, (k - 5) / 4 % 2 == 0);
      else              chk("f55_stop",  bus.txd, 1);
      if (k == 40) chk("f55_busy_hi", bus.busy, 1);
      if (k == 41) chk("f55_busy_lo", bus.busy, 0);
    end
    drain();
    chk("f55_rx_len", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("f55_rx", rx_q[0], 8'h55);

    // back-to-back frames, no idle gap
    clear_lists();
    step(1'b1, 8'h41);
    step(1'b1, 8'h42);
    repeat (39) step(1'b0, 8'h00);
    chk("b2b_stop", bus.txd, 1);
    step(1'b0, 8'h00);
    chk("b2b_start2", bus.txd, 0);
    drain();
    chk("b2b_len", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", rx_q[0], 8'h41);
      chk("b2b_rx1", rx_q[1], 8'h42);
    end

    // overflow table: 0x10..0x15 on consecutive cycles
    clear_lists();
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].wr, vecs[i].data);
      chk("tbl_count", bus.count, vecs[i].cnt);
      chk("tbl_full",  bus.full,  vecs[i].full);
      chk("tbl_busy",  bus.busy,  vecs[i].busy);
      chk("tbl_txd",   bus.txd,   vecs[i].txd);
    end
    drain();
    chk("ovf_len", rx_q.size(), 5);
    for (int i = 0; i < rx_q.size() && i < 5; i++) chk("ovf_rx", rx_q[i], 8'h10 + 8'(i));

    // write on the exact edge the stop bit pops
    clear_lists();
    step(1'b1, 8'hA1);
    step(1'b1, 8'hB2);
    repeat (39) step(1'b0, 8'h00);
    step(1'b1, 8'hC3);
    chk("stoppop_count", bus.count, 1);
    chk("stoppop_txd", bus.txd, 0);
    drain();
    chk("stoppop_len", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("stoppop_rx0", rx_q[0], 8'hA1);
      chk("stoppop_rx1", rx_q[1], 8'hB2);
      chk("stoppop_rx2", rx_q[2], 8'hC3);
    end

    // 12 paced random bytes: pointers wrap three times
    clear_lists();
    wl.delete();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 30)) step(1'b0, 8'h00);
      while (mq.size() >= DEPTH) step(1'b0, 8'h00);
      d = 8'($urandom);
      wl.push_back(d);
      step(1'b1, d);
    end
    drain();
    chk("wrap_len", rx_q.size(), 12);
    for (int i = 0; i < rx_q.size() && i < 12; i++) chk("wrap_rx", rx_q[i], wl[i]);

    // random traffic including overflow
    clear_lists();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 5) == 0, 8'($urandom));
    drain();
    rx_vs_model();

    // asynchronous reset in the middle of a data bit
    clear_lists();
    step(1'b1, 8'h0F);
    step(1'b1, 8'hF0);
    repeat (12) step(1'b0, 8'h00);
    #2;
    reset = 1'b1;
    rst_cnt++;
    #1;
    chk("mrst_txd", bus.txd, 1); chk("mrst_count", bus.count, 0);
    chk("mrst_busy", bus.busy, 0); chk("mrst_full", bus.full, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    free_at  = e;
    pop_edge = -1000;
    repeat (60) step(1'b0, 8'h00);
    chk("mrst_idle_txd", bus.txd, 1);
    clear_lists();
    step(1'b1, 8'h3C);
    drain();
    chk("mrst_len", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("mrst_rx", rx_q[0], 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter that drives the board-level `txd` pin of the Arty S7 top.
- Sits downstream of the I/O bus: the CPU's store to the UART data address becomes a one-cycle `wr_en` pulse with a byte.
- The block queues bytes in a small FIFO and serialises them as 8N1 frames, LSB first.
- Software can poll `full` and `busy` through the bus status register.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 2.
DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
wr_en  input  1  byte write strobe from I/O bus.
wr_data  input  8  byte to transmit.
full  output  1  FIFO holds DEPTH entries; writes are ignored.
count  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
busy  output  1  high while a frame is on the line or FIFO non-empty.
txd  output  1  serial line; idle high.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-high. While reset is asserted: txd=1, full=0, count=0, busy=0, FSM=IDLE, FIFO pointers=0, baud counter=0, bit index=0. All outputs are registered or decoded from registers; no combinational path from wr_en to any output.
- FIFO write: on a clk edge with wr_en=1 and full=0, wr_data is stored at wr_ptr, wr_ptr increments mod DEPTH, count increments.
  - wr_en=1 with full=1: byte dropped, no state change.
- FIFO pop: occurs on the edge where the FSM leaves IDLE or STOP toward START; rd_ptr increments mod DEPTH and the byte is latched into the shift register.
  - Push and pop on the same edge: count unchanged; both pointers advance.
  - A pop never reads a byte written on that same edge: count must be >=1 before the edge.
- full = (count==DEPTH). busy = (FSM!=IDLE) || (count!=0).
- FSM states: IDLE, START, DATA, STOP. Baud counter runs 0..CLKS_PER_BIT-1 inside START/DATA/STOP; "bit end" = counter==CLKS_PER_BIT-1.
  - IDLE: txd=1. If count!=0 at an edge: pop, counter=0, go START, txd=0 from that edge.
  - START: txd=0 for CLKS_PER_BIT cycles; at bit end go DATA, bit index=0, txd=shift[0].
  - DATA: txd=shift[bit index]. At bit end: if index==7 go STOP with txd=1; else index+1.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At bit end: if count!=0, pop and go START directly (txd=0 on that edge, no idle gap); else go IDLE.
- Latency: wr_en to an idle, empty block at edge N means count=1 after N, and txd falls after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles from the txd falling edge to the end of the stop bit.
- wr_en during a frame affects only the FIFO; the shift register is stable for the whole frame.
- Pointer wrap: after DEPTH pushes and pops the pointers return to 0; the data order is preserved across the wrap.
- Reset mid-frame: txd returns to 1 immediately (asynchronous), the FIFO is emptied, and the partially sent byte is discarded. After release the block idles until a new write.

Test Plan (CLKS_PER_BIT=4, DEPTH=4 unless noted):
- Reset pulse while the FSM is in DATA -> txd=1 within the same cycle, count=0, busy=0, full=0; no further txd transitions until the next write.
- Single write 0x55 at edge N -> txd low on cycles N+1..N+4, then 1,0,1,0,1,0,1,0 for 4 cycles each, then stop high 4 cycles; busy drops 40 cycles after N+1.
- Back-to-back writes 0x41,0x42 -> two frames with no idle gap (stop of 0x41 immediately followed by start of 0x42); decoded bytes 0x41 then 0x42.
- Write 6 bytes 0x10..0x15 on consecutive cycles -> first pops at once, count peaks at 4, full=1, 0x15 dropped; line carries 0x10..0x14 only.
- Write on the exact edge the STOP state pops (count=1) -> count stays 1; byte order preserved.
- Push 12 bytes paced so the FIFO wraps pointers 3 times -> all 12 bytes decoded in order; default CLKS_PER_BIT=868 gives a bit period of 8680 ns at 10 ns clk.
